// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: pipeline writeback (A) vs one buffered long-latency result (B).
// A has priority. The buffered entry forces a pipeline hold after MAX_WAIT lost cycles.
module wb_port_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_we_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_data_i,
   input  logic              b_valid_i,
   output logic              b_ready_o,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_data_i,
   output logic              hold_o,
   output logic              pend_valid_o,
   output logic [ADDR_W-1:0] pend_addr_o,
   output logic              rf_we_o,
   output logic [ADDR_W-1:0] rf_addr_o,
   output logic [DATA_W-1:0] rf_data_o
);
   localparam int WCW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   state_t            state, state_nxt;
   logic [WCW-1:0]    wait_cnt, wait_cnt_nxt;
   logic [ADDR_W-1:0] buf_addr;
   logic [DATA_W-1:0] buf_data;
   logic              accept;
   wr_t               grant;

   assign b_ready_o    = (state == IDLE);
   assign hold_o       = (state == FORCE);
   assign pend_valid_o = (state != IDLE);
   assign pend_addr_o  = (state == IDLE) ? '0 : buf_addr;
   assign accept       = b_valid_i && b_ready_o;

   wr_t a_req, b_req;
   assign a_req = '{we: a_we_i, addr: a_addr_i, data: a_data_i};
   assign b_req = '{we: 1'b1,   addr: buf_addr, data: buf_data};

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      grant        = a_req;
      unique case (state)
         IDLE: begin
            grant = a_req;
            if (accept) begin
               state_nxt    = PEND;
               wait_cnt_nxt = '0;
            end
         end
         PEND: begin
            if (a_we_i) begin
               grant = a_req;
               // A is younger than the buffered result, so it supersedes it.
               if (a_addr_i == buf_addr && buf_addr != '0) begin
                  state_nxt    = IDLE;
                  wait_cnt_nxt = '0;
               end else if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
                  state_nxt    = FORCE;
                  wait_cnt_nxt = WCW'(MAX_WAIT);
               end else begin
                  wait_cnt_nxt = wait_cnt + 1'b1;
               end
            end else begin
               grant        = b_req;
               state_nxt    = IDLE;
               wait_cnt_nxt = '0;
            end
         end
         FORCE: begin
            grant        = b_req;
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
         end
         default: begin
            grant     = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         buf_addr  <= '0;
         buf_data  <= '0;
         rf_we_o   <= 1'b0;
         rf_addr_o <= '0;
         rf_data_o <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (accept) begin
            buf_addr <= b_addr_i;
            buf_data <= b_data_i;
         end
         // x0 is hardwired zero: never issue a write to it.
         rf_we_o   <= grant.we && (grant.addr != '0);
         rf_addr_o <= grant.addr;
         rf_data_o <= grant.data;
      end
   end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Owns the single regfile write port. Shares it between the in-order pipeline writeback (mem/wb stage output) and a long-latency unit (divider / late load return) with a valid/ready handshake. Holds one pending long-latency result in a 1-entry buffer. Asserts a pipeline hold when that result has waited too long. Sits between mem_wb and regfile.

Parameters:
DATA_W, 32, register data width (REG_BUS_WIDTH)
ADDR_W, 5, register address width (REG_ADDR_BUS_WIDTH)
MAX_WAIT, 4, max consecutive cycles the buffered entry may lose arbitration before hold is forced (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
a_we_i  input  1  pipeline writeback enable
a_addr_i  input  ADDR_W  pipeline destination register
a_data_i  input  DATA_W  pipeline writeback data
b_valid_i  input  1  long-latency result valid
b_ready_o  output  1  buffer can accept a long-latency result
b_addr_i  input  ADDR_W  long-latency destination register
b_data_i  input  DATA_W  long-latency result data
hold_o  output  1  freeze pipeline; mem_wb keeps presenting a_* unchanged next cycle
pend_valid_o  output  1  buffer holds an unwritten result (for hazard detection)
pend_addr_o  output  ADDR_W  destination of buffered result
rf_we_o  output  1  regfile write enable (registered)
rf_addr_o  output  ADDR_W  regfile write address (registered)
rf_data_o  output  DATA_W  regfile write data (registered)

Behaviour:
- Single clock clk; rst_n asynchronous, active-low.
- Reset: state IDLE, buffer empty, wait_cnt=0, rf_we_o=0, rf_addr_o=0, rf_data_o=0. Combinational outputs then read hold_o=0, b_ready_o=1, pend_valid_o=0, pend_addr_o=0.
- States: IDLE (buffer empty), PEND (buffer full, A has priority), FORCE (buffer full, must write this cycle).
- b_ready_o = (state==IDLE). hold_o = (state==FORCE). pend_valid_o = (state!=IDLE). pend_addr_o = buffered address, 0 in IDLE.
- Handshake: b_valid_i && b_ready_o at a clock edge loads the buffer and moves to PEND with wait_cnt=0. B always passes through the buffer. Earliest B write is 1 cycle after acceptance; it appears on rf_* 2 edges after acceptance.
- Grant each cycle:
  - IDLE: A.
  - PEND: A if a_we_i, else buffer.
  - FORCE: buffer. A is ignored because hold_o=1 and A re-presents next cycle.
- Output register: rf_* load the granted source every edge. rf_we_o=0 when nothing is granted or the granted addr==0 (x0 never written). One cycle latency from the grant.
- PEND, A granted: wait_cnt++. If wait_cnt reaches MAX_WAIT, go to FORCE.
- PEND or FORCE, buffer granted: buffer empties, go to IDLE, wait_cnt=0.
- Same-address override: in PEND with a_we_i && a_addr_i==buffered addr (nonzero), A is written and the buffer is dropped (A is younger). Go to IDLE. The stale B value is never written.
- B with b_addr_i==0: accepted normally; the buffer still passes through PEND; its grant produces rf_we_o=0.
- No accept in the cycle the buffer drains. b_ready_o rises the cycle after the drain.
- wait_cnt width: clog2(MAX_WAIT+1). It never wraps; it saturates at MAX_WAIT via the FORCE transition.
- Reset mid-operation: buffer content discarded, no write issued, hold_o drops immediately.

Test Plan:
1. Assert rst_n=0 at an arbitrary point, including while in PEND -> rf_we_o=0, rf_addr_o=0, rf_data_o=0, hold_o=0, pend_valid_o=0, b_ready_o=1 without waiting for clk.
2. A only: a_we_i=1, addr=3, data=0x000000AA at cycle 0 -> after edge 1: rf_we_o=1, rf_addr_o=3, rf_data_o=0xAA. Then a_we_i=0 -> rf_we_o=0 next edge.
3. B only: b_valid_i=1, addr=5, data=0x1234 in cycle 0 -> cycle 1: b_ready_o=0, pend_valid_o=1, pend_addr_o=5. After edge 2: rf_we_o=1, addr=5, data=0x1234. Cycle 2: b_ready_o=1.
4. Starvation, MAX_WAIT=4: B addr=9 accepted. A writes addr 1,2,3,4 on consecutive cycles, all granted. hold_o=1 exactly one cycle while A presents addr 5 -> rf writes addr 9, then addr 5 the following cycle. No A write lost or duplicated.
5. Override: B addr=7, data=0x11 buffered; next cycle A writes addr 7, data=0x22 -> rf writes 7/0x22. pend_valid_o=0 next cycle. No further write to 7 is observed.
6. x0 suppression: A addr=0, data=0xFF -> rf_we_o=0. B addr=0 -> handshake completes, buffer drains in one cycle, rf_we_o stays 0.
